// File: rtl/management_tx_frame_fifo.sv
// Frame FIFO from the management register interface to the management MAC TX bus.
// Serializes strobed words to bytes, holds whole frames and releases only committed ones.
module management_tx_frame_fifo #(
    parameter int IN_WIDTH      = 16,
    parameter int DATA_DEPTH    = 4096,
    parameter int HDR_DEPTH     = 32,
    parameter int MAX_FRAME_LEN = 1522
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [IN_WIDTH-1:0]           wr_data,
    input  logic [IN_WIDTH/8-1:0]         wr_strb,
    input  logic                          wr_commit,
    input  logic                          wr_abort,
    output logic                          wr_ready,
    input  logic                          flush,
    input  logic                          tx_ready,
    output logic                          tx_start,
    output logic                          tx_data_valid,
    output logic [7:0]                    tx_data,
    output logic [$clog2(HDR_DEPTH):0]    frames_pending,
    output logic [$clog2(DATA_DEPTH):0]   free_bytes,
    output logic [15:0]                   drop_count
);

    localparam int SW = IN_WIDTH / 8;
    localparam int LW = $clog2(SW);
    localparam int AW = $clog2(DATA_DEPTH);
    localparam int HW = $clog2(HDR_DEPTH);

    if ((IN_WIDTH != 16) && (IN_WIDTH != 32)) begin : g_bad_width
        $error("management_tx_frame_fifo: IN_WIDTH must be 16 or 32");
    end
    if (MAX_FRAME_LEN >= 2048) begin : g_bad_max_len
        $error("management_tx_frame_fifo: MAX_FRAME_LEN must be below 2048");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEND
    } rd_state_t;

    // Storage
    logic [7:0]  data_mem [DATA_DEPTH];
    logic [10:0] hdr_mem  [HDR_DEPTH];
    logic [7:0]  ram_q;
    logic [10:0] len_q;

    // Write-side state
    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      frame_start_reg, frame_start_next;
    logic [10:0]      frame_len_reg, frame_len_next;
    logic             bad_reg, bad_next;
    logic [SW-1:0]    pend_strb_reg, pend_strb_next;
    logic [IN_WIDTH-1:0] pend_data_reg, pend_data_next;
    logic             pend_commit_reg, pend_commit_next;
    logic             pend_abort_reg, pend_abort_next;
    logic [HW:0]      hdr_wr_ptr_reg, hdr_wr_ptr_next;
    logic [15:0]      drop_count_reg, drop_count_next;
    logic             flush_pend_reg, flush_pend_next;

    // Read-side state
    rd_state_t        state_reg, state_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [HW:0]      hdr_rd_ptr_reg, hdr_rd_ptr_next;
    logic [10:0]      rd_left_reg, rd_left_next;
    logic             tx_valid_reg;

    // Serializer datapath
    logic                busy;
    logic [IN_WIDTH-1:0] src_data;
    logic [SW-1:0]       src_strb;
    logic                src_commit;
    logic                src_abort;
    logic [SW-1:0]       rem_strb;
    logic [LW-1:0]       lane_sel;
    logic [7:0]          src_lanes [SW];
    logic [7:0]          push_byte;
    logic                push_en;

    // Frame bookkeeping
    logic [AW:0]  occupancy;
    logic         buf_full;
    logic         too_long;
    logic         byte_ok;
    logic [AW:0]  wr_ptr_pushed;
    logic [10:0]  len_pushed;
    logic         bad_pushed;
    logic         word_done;
    logic         do_abort;
    logic         do_commit;
    logic [HW:0]  hdr_count;
    logic         hdr_full;
    logic         commit_good;
    logic         commit_drop;
    logic         flush_apply;
    logic         rd_en;
    logic         hdr_pop;

    assign busy     = (pend_strb_reg != '0);
    assign wr_ready = !busy && !flush_pend_reg;

    // A word still being serialized takes priority; new inputs are only looked at when idle.
    always_comb begin
        if (busy) begin
            src_data   = pend_data_reg;
            src_strb   = pend_strb_reg;
            src_commit = pend_commit_reg;
            src_abort  = pend_abort_reg;
        end else begin
            src_data   = wr_data;
            src_strb   = (wr_valid && wr_ready) ? wr_strb : '0;
            src_commit = wr_ready && wr_commit;
            src_abort  = wr_ready && wr_abort;
        end
    end

    for (genvar gi = 0; gi < SW; gi++) begin : g_lanes
        assign src_lanes[gi] = src_data[8*gi +: 8];
    end

    always_comb begin
        lane_sel = '0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (src_strb[i]) begin
                lane_sel = LW'(i);
            end
        end
    end

    assign push_byte = src_lanes[lane_sel];
    assign push_en   = (src_strb != '0);
    assign rem_strb  = src_strb & (src_strb - SW'(1));
    assign word_done = (rem_strb == '0);

    assign occupancy     = wr_ptr_reg - rd_ptr_reg;
    assign buf_full      = (occupancy == (AW+1)'(DATA_DEPTH));
    assign too_long      = (frame_len_reg == 11'(MAX_FRAME_LEN));
    assign byte_ok       = push_en && !bad_reg && !buf_full && !too_long;
    assign wr_ptr_pushed = wr_ptr_reg + (AW+1)'(byte_ok);
    assign len_pushed    = frame_len_reg + 11'(byte_ok);
    assign bad_pushed    = bad_reg || (push_en && !byte_ok);

    // Commit/abort take effect only after the last lane of the word has been pushed.
    assign do_abort    = word_done && src_abort;
    assign do_commit   = word_done && src_commit && !src_abort;
    assign hdr_count   = hdr_wr_ptr_reg - hdr_rd_ptr_reg;
    assign hdr_full    = (hdr_count == (HW+1)'(HDR_DEPTH));
    assign commit_good = do_commit && !bad_pushed && (len_pushed != '0) && !hdr_full;
    assign commit_drop = do_commit && (bad_pushed || ((len_pushed != '0) && hdr_full));
    assign flush_apply = flush_pend_reg && (state_reg == ST_IDLE);

    always_comb begin
        wr_ptr_next      = wr_ptr_pushed;
        frame_start_next = frame_start_reg;
        frame_len_next   = len_pushed;
        bad_next         = bad_pushed;
        pend_strb_next   = rem_strb;
        pend_data_next   = pend_data_reg;
        pend_commit_next = 1'b0;
        pend_abort_next  = 1'b0;
        hdr_wr_ptr_next  = hdr_wr_ptr_reg;
        drop_count_next  = drop_count_reg;
        flush_pend_next  = (flush_pend_reg && !flush_apply) || flush;

        if (!word_done) begin
            pend_data_next   = src_data;
            pend_commit_next = src_commit;
            pend_abort_next  = src_abort;
        end

        if (do_abort) begin
            wr_ptr_next    = frame_start_reg;
            frame_len_next = '0;
            bad_next       = 1'b0;
        end else if (commit_good) begin
            hdr_wr_ptr_next  = hdr_wr_ptr_reg + (HW+1)'(1);
            frame_start_next = wr_ptr_pushed;
            frame_len_next   = '0;
        end else if (commit_drop) begin
            wr_ptr_next    = frame_start_reg;
            frame_len_next = '0;
            bad_next       = 1'b0;
            if (drop_count_reg != 16'hffff) begin
                drop_count_next = drop_count_reg + 16'd1;
            end
        end

        // Flush discards the in-progress frame and anything the serializer still holds.
        if (flush_apply) begin
            wr_ptr_next      = frame_start_reg;
            frame_start_next = frame_start_reg;
            frame_len_next   = '0;
            bad_next         = 1'b0;
            pend_strb_next   = '0;
            pend_commit_next = 1'b0;
            pend_abort_next  = 1'b0;
            hdr_wr_ptr_next  = hdr_wr_ptr_reg;
            drop_count_next  = drop_count_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_en        = 1'b0;
        hdr_pop      = 1'b0;
        rd_left_next = rd_left_reg;
        case (state_reg)
            ST_IDLE: begin
                if ((hdr_count != '0) && tx_ready && !flush_pend_reg && !flush) begin
                    hdr_pop    = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                rd_en        = 1'b1;
                rd_left_next = len_q - 11'd1;
                state_next   = (len_q == 11'd1) ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                rd_en        = 1'b1;
                rd_left_next = rd_left_reg - 11'd1;
                if (rd_left_reg == 11'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rd_ptr_next     = flush_apply ? frame_start_reg : rd_ptr_reg + (AW+1)'(rd_en);
    assign hdr_rd_ptr_next = flush_apply ? hdr_wr_ptr_reg : hdr_rd_ptr_reg + (HW+1)'(hdr_pop);

    always_ff @(posedge clk) begin
        if (byte_ok) begin
            data_mem[wr_ptr_reg[AW-1:0]] <= push_byte;
        end
        if (rd_en) begin
            ram_q <= data_mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (commit_good) begin
            hdr_mem[hdr_wr_ptr_reg[HW-1:0]] <= len_pushed;
        end
        if (hdr_pop) begin
            len_q <= hdr_mem[hdr_rd_ptr_reg[HW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg      <= '0;
            frame_start_reg <= '0;
            frame_len_reg   <= '0;
            bad_reg         <= 1'b0;
            pend_strb_reg   <= '0;
            pend_data_reg   <= '0;
            pend_commit_reg <= 1'b0;
            pend_abort_reg  <= 1'b0;
            hdr_wr_ptr_reg  <= '0;
            drop_count_reg  <= '0;
            flush_pend_reg  <= 1'b0;
            state_reg       <= ST_IDLE;
            rd_ptr_reg      <= '0;
            hdr_rd_ptr_reg  <= '0;
            rd_left_reg     <= '0;
            tx_valid_reg    <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            frame_start_reg <= frame_start_next;
            frame_len_reg   <= frame_len_next;
            bad_reg         <= bad_next;
            pend_strb_reg   <= pend_strb_next;
            pend_data_reg   <= pend_data_next;
            pend_commit_reg <= pend_commit_next;
            pend_abort_reg  <= pend_abort_next;
            hdr_wr_ptr_reg  <= hdr_wr_ptr_next;
            drop_count_reg  <= drop_count_next;
            flush_pend_reg  <= flush_pend_next;
            state_reg       <= state_next;
            rd_ptr_reg      <= rd_ptr_next;
            hdr_rd_ptr_reg  <= hdr_rd_ptr_next;
            rd_left_reg     <= rd_left_next;
            tx_valid_reg    <= rd_en;
        end
    end

    assign tx_start       = (state_reg == ST_HDR);
    assign tx_data_valid  = tx_valid_reg;
    assign tx_data        = tx_valid_reg ? ram_q : 8'h00;
    assign frames_pending = hdr_count;
    assign free_bytes     = (AW+1)'(DATA_DEPTH) - occupancy;
    assign drop_count     = drop_count_reg;

endmodule
